// File: rtl/dna_pattern_search.sv
// Streaming nucleotide pattern searcher: sliding window over a 1-cycle-latency
// sequence memory, approximate match with mismatch budget, 2-entry result FIFO.

module dna_pattern_lane (
  input  logic [1:0] nuc,
  input  logic [1:0] pat,
  input  logic       en,
  output logic       miss
);
  assign miss = en && (nuc != pat);
endmodule

module dna_pattern_search #(
  parameter int ADDR_W  = 16,
  parameter int PAT_MAX = 8,
  parameter int LEN_W   = 4
) (
  input  logic                 clock,
  input  logic                 reset_N,
  input  logic                 ready,
  input  logic [ADDR_W-1:0]    dna_start,
  input  logic [ADDR_W-1:0]    dna_length,
  input  logic [2*PAT_MAX-1:0] pattern,
  input  logic [LEN_W-1:0]     pat_len,
  input  logic [LEN_W-1:0]     max_mm,
  input  logic                 find_all,
  output logic                 seq_re,
  output logic [ADDR_W-1:0]    seq_addr,
  input  logic [1:0]           seq_data,
  output logic                 match_valid,
  input  logic                 match_ready,
  output logic [ADDR_W-1:0]    match_location,
  output logic [ADDR_W-1:0]    found_location,
  output logic [ADDR_W-1:0]    match_count,
  output logic                 found_it,
  output logic                 done,
  output logic                 error
);
  localparam int IDX_W = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]                state;
  logic [ADDR_W-1:0]         rem, rx_addr;
  logic                      inflight;
  logic [LEN_W-1:0]          rcv, plen_r, mm_r;
  logic                      all_r;
  logic [PAT_MAX-1:0][1:0]   win, win_next, pat_r;
  logic [1:0][ADDR_W-1:0]    fifo_mem;
  logic                      wr_ptr, rd_ptr;
  logic [1:0]                f_cnt;

  logic [PAT_MAX-1:0]        miss;
  logic [LEN_W-1:0]          mm_cnt;
  logic                      rx_ok, enough, hit, stop, pop, cfg_bad;
  logic [2:0]                occ;
  logic [ADDR_W:0]           span;
  logic [ADDR_W-1:0]         loc;

  // Index 0 holds the newest nucleotide; seq[loc+i] sits at win_next[plen-1-i].
  assign win_next = {win[PAT_MAX-2:0], seq_data};

  for (genvar i = 0; i < PAT_MAX; i++) begin : g_lane
    logic [IDX_W-1:0] idx;
    logic             en;
    assign en  = LEN_W'(i) < plen_r;
    assign idx = IDX_W'(plen_r - LEN_W'(i + 1));
    dna_pattern_lane u_lane (
      .nuc  (win_next[idx]),
      .pat  (pat_r[i]),
      .en   (en),
      .miss (miss[i])
    );
  end

  always_comb begin
    mm_cnt = '0;
    for (int i = 0; i < PAT_MAX; i++) mm_cnt = mm_cnt + LEN_W'(miss[i]);
  end

  assign rx_ok  = inflight && (state == S_FETCH);
  assign enough = ({1'b0, rcv} + (LEN_W+1)'(1)) >= {1'b0, plen_r};
  assign hit    = rx_ok && enough && (mm_cnt <= mm_r);
  assign stop   = hit && !all_r;
  assign loc    = rx_addr - ADDR_W'(plen_r) + ADDR_W'(1);

  assign match_valid    = (f_cnt != 2'd0);
  assign match_location = fifo_mem[rd_ptr];
  assign pop            = match_valid && match_ready;
  assign done           = (state == S_DONE) || (state == S_ERR);

  // A read is allowed only if its data is guaranteed a free FIFO slot on return.
  assign occ    = {1'b0, f_cnt} - {2'b0, pop} + {2'b0, inflight};
  assign seq_re = (state == S_FETCH) && (rem != '0) && !stop && (occ < 3'd2);

  // start + length exceeding 2^ADDR_W means the last address is out of range
  assign span    = {1'b0, dna_start} + {1'b0, dna_length};
  assign cfg_bad = (pat_len == '0) || (pat_len > LEN_W'(PAT_MAX)) ||
                   (dna_length < ADDR_W'(pat_len)) ||
                   (span > {1'b1, {ADDR_W{1'b0}}});

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state          <= S_IDLE;
      seq_addr       <= '0;
      rem            <= '0;
      rx_addr        <= '0;
      inflight       <= 1'b0;
      rcv            <= '0;
      plen_r         <= '0;
      mm_r           <= '0;
      all_r          <= 1'b0;
      win            <= '0;
      pat_r          <= '0;
      found_location <= '0;
      match_count    <= '0;
      found_it       <= 1'b0;
      error          <= 1'b0;
    end else begin
      inflight <= seq_re;
      if (seq_re) begin
        seq_addr <= seq_addr + ADDR_W'(1);
        rem      <= rem - ADDR_W'(1);
        rx_addr  <= seq_addr;
      end
      case (state)
        S_IDLE: if (ready) begin
          pat_r          <= pattern;
          plen_r         <= pat_len;
          mm_r           <= max_mm;
          all_r          <= find_all;
          seq_addr       <= dna_start;
          rem            <= dna_length;
          rcv            <= '0;
          win            <= '0;
          found_location <= '0;
          match_count    <= '0;
          found_it       <= 1'b0;
          error          <= cfg_bad;
          state          <= cfg_bad ? S_ERR : S_FETCH;
        end
        S_FETCH: begin
          if (rx_ok) begin
            win <= win_next;
            if (!enough) rcv <= rcv + LEN_W'(1);
          end
          if (hit) begin
            found_location <= loc;
            found_it       <= 1'b1;
            if (match_count != '1) match_count <= match_count + ADDR_W'(1);
          end
          if (stop || (rx_ok && rem == '0)) state <= S_DRAIN;
        end
        S_DRAIN: if (f_cnt == 2'd0) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      fifo_mem <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      f_cnt    <= 2'd0;
    end else begin
      if (hit) begin
        fifo_mem[wr_ptr] <= loc;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({hit, pop})
        2'b10:   f_cnt <= f_cnt + 2'd1;
        2'b01:   f_cnt <= f_cnt - 2'd1;
        default: f_cnt <= f_cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_dna_pattern_search.sv
// Directed bench for dna_pattern_search: a window-by-window reference search
// over the bench memory predicts every result, and a negedge monitor checks pops.

module tb_dna_pattern_search;
  localparam int ADDR_W = 16, PAT_MAX = 8, LEN_W = 4;

  logic              clock = 1'b0, reset_N = 1'b0, ready = 1'b0;
  logic [ADDR_W-1:0] dna_start = '0, dna_length = '0;
  logic [2*PAT_MAX-1:0] pattern = '0;
  logic [LEN_W-1:0]  pat_len = '0, max_mm = '0;
  logic              find_all = 1'b0, match_ready = 1'b1;
  logic              seq_re, match_valid, found_it, done, error;
  logic [ADDR_W-1:0] seq_addr, match_location, found_location, match_count;
  logic [1:0]        seq_data = 2'd0;

  dna_pattern_search #(.ADDR_W(ADDR_W), .PAT_MAX(PAT_MAX), .LEN_W(LEN_W)) dut (
    .clock(clock), .reset_N(reset_N), .ready(ready), .dna_start(dna_start),
    .dna_length(dna_length), .pattern(pattern), .pat_len(pat_len), .max_mm(max_mm),
    .find_all(find_all), .seq_re(seq_re), .seq_addr(seq_addr), .seq_data(seq_data),
    .match_valid(match_valid), .match_ready(match_ready), .match_location(match_location),
    .found_location(found_location), .match_count(match_count), .found_it(found_it),
    .done(done), .error(error)
  );

  always #5 clock = ~clock;

  logic [1:0] mem [0:65535];
  always @(posedge clock) if (seq_re) seq_data <= mem[seq_addr];

  int checks = 0, errors = 0;
  int exp_q[$];
  int exp_total, exp_last;
  bit exp_err;
  int seq_cnt, done_cnt, seq_run, seq_run_max, pop_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: slide over every window start, count mismatching positions.
  task automatic build_model(input int st, input int ln, input logic [15:0] pt,
                             input int pl, input int mm, input bit fa);
    int d;
    exp_q.delete();
    exp_total = 0;
    exp_last  = 0;
    exp_err   = (pl == 0) || (pl > PAT_MAX) || (ln < pl) || (st + ln - 1 > 65535);
    if (!exp_err) begin
      for (int l = st; l + pl <= st + ln; l++) begin
        d = 0;
        for (int i = 0; i < pl; i++) if (mem[l+i] != pt[2*i +: 2]) d++;
        if (d <= mm) begin
          exp_q.push_back(l);
          exp_total++;
          exp_last = l;
          if (!fa) break;
        end
      end
    end
  endtask

  always @(negedge clock) if (reset_N) begin
    if (seq_re) begin
      seq_cnt++;
      seq_run++;
      if (seq_run > seq_run_max) seq_run_max = seq_run;
    end else seq_run = 0;
    if (done) done_cnt++;
    if (match_valid && match_ready) begin
      pop_cnt++;
      if (exp_q.size() == 0) chk("unexpected_match", {16'd0, match_location}, 32'hFFFF_FFFF);
      else chk("match_location", {16'd0, match_location}, exp_q.pop_front());
    end
  end

  task automatic launch(input int st, input int ln, input logic [15:0] pt,
                        input int pl, input int mm, input bit fa, input bit mrdy);
    build_model(st, ln, pt, pl, mm, fa);
    seq_cnt = 0; done_cnt = 0; seq_run = 0; seq_run_max = 0; pop_cnt = 0;
    dna_start = ADDR_W'(st); dna_length = ADDR_W'(ln); pattern = pt;
    pat_len = LEN_W'(pl); max_mm = LEN_W'(mm); find_all = fa; match_ready = mrdy;
    @(posedge clock) #1 ready = 1'b1;
    @(posedge clock) #1 ready = 1'b0;
    dna_start = 16'hABCD; dna_length = 16'h0001; pattern = ~pt;
    pat_len = 4'd0; max_mm = 4'd0; find_all = ~fa;
  endtask

  task automatic run(input int st, input int ln, input logic [15:0] pt, input int pl,
                     input int mm, input bit fa, input int rdy_delay, input int exp_seq,
                     input int exp_run, input bit bp);
    int cyc;
    launch(st, ln, pt, pl, mm, fa, rdy_delay == 0);
    cyc = 0;
    while (done_cnt == 0 && cyc < 600) begin
      @(posedge clock) #1;
      cyc++;
      if (bp && cyc == 15) begin
        chk("bp_fifo_valid", match_valid, 1);
        chk("bp_seq_re_stalled", seq_re, 0);
        chk("bp_reads_before_stall", seq_cnt, 3);
      end
      if (cyc == rdy_delay) match_ready = 1'b1;
    end
    if (done_cnt == 0) begin
      checks++; errors++;
      $display("FAIL timeout_done actual=no_done required=done");
    end
    repeat (6) @(posedge clock);
    #1;
    chk("done_pulses", done_cnt, 1);
    chk("match_count", {16'd0, match_count}, exp_total);
    chk("found_it", found_it, exp_total > 0);
    chk("found_location", {16'd0, found_location}, exp_last);
    chk("error", error, exp_err);
    chk("missing_matches", exp_q.size(), 0);
    chk("pop_count", pop_cnt, exp_total);
    chk("match_valid_after", match_valid, 0);
    if (exp_seq >= 0) chk("seq_re_cycles", seq_cnt, exp_seq);
    if (exp_run >= 0) chk("seq_re_run", seq_run_max, exp_run);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_seq_re"}, seq_re, 0);
    chk({tag, "_seq_addr"}, {16'd0, seq_addr}, 0);
    chk({tag, "_match_valid"}, match_valid, 0);
    chk({tag, "_match_location"}, {16'd0, match_location}, 0);
    chk({tag, "_found_location"}, {16'd0, found_location}, 0);
    chk({tag, "_match_count"}, {16'd0, match_count}, 0);
    chk({tag, "_found_it"}, found_it, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 2'd0;
    for (int i = 0; i < 8; i++) mem[16+i] = 2'(i % 4);  // ACGTACGT at 0x10

    repeat (3) @(posedge clock);
    #1 check_zero_outputs("reset");
    reset_N = 1'b1;

    // ACG, exact, find-all
    build_model(16, 8, 16'h0024, 3, 0, 1);
    chk("model_s1_n", exp_q.size(), 2);
    chk("model_s1_first", exp_q[0], 32'h10);
    chk("model_s1_second", exp_q[1], 32'h14);
    run(16, 8, 16'h0024, 3, 0, 1, 0, 8, 8, 0);

    // ACG, find-first
    build_model(16, 8, 16'h0024, 3, 0, 0);
    chk("model_s2_n", exp_q.size(), 1);
    run(16, 8, 16'h0024, 3, 0, 0, 0, 3, -1, 0);

    // AGG with one mismatch allowed
    build_model(16, 8, 16'h0028, 3, 1, 1);
    chk("model_s3_n", exp_q.size(), 2);
    chk("model_s3_last", exp_last, 32'h14);
    run(16, 8, 16'h0028, 3, 1, 1, 0, 8, 8, 0);

    // configuration errors
    build_model(16'hFFFE, 4, 16'h0024, 3, 0, 1);
    chk("model_err_range", exp_err, 1);
    run(16, 8, 16'h0024, 0, 0, 1, 0, 0, -1, 0);
    run(16, 8, 16'h0024, PAT_MAX + 1, 0, 1, 0, 0, -1, 0);
    run(16, 2, 16'h0024, 3, 0, 1, 0, 0, -1, 0);
    run(16'hFFFE, 4, 16'h0024, 3, 0, 1, 0, 0, -1, 0);

    // backpressure on 16 A's with pattern AA
    build_model(0, 16, 16'h0000, 2, 0, 1);
    chk("model_bp_n", exp_q.size(), 15);
    run(0, 16, 16'h0000, 2, 0, 1, 20, 16, -1, 1);

    // reset mid-FETCH, then repeat the first scenario
    launch(16, 8, 16'h0024, 3, 0, 1, 1);
    repeat (2) @(posedge clock);
    #1 reset_N = 1'b0;
    #1 check_zero_outputs("midreset");
    @(posedge clock) #1 reset_N = 1'b1;
    exp_q.delete();
    run(16, 8, 16'h0024, 3, 0, 1, 0, 8, 8, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
